// File: rtl/video_pkg.sv
// Shared video types and channel expansion helpers for the frame buffer streaming path.
package video_pkg;

  localparam int unsigned H_PIXELS_DEF = 320;
  localparam int unsigned V_LINES_DEF  = 240;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pix444_t;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } pix30_t;

  // Replicate the nibble so full scale maps near full scale (0xF -> 0x3FC).
  function automatic logic [9:0] expand4to10(input logic [3:0] c);
    return {c, c, 2'b00};
  endfunction

  function automatic pix30_t expand_pix(input pix444_t p);
    pix30_t q;
    q.r = expand4to10(p.r);
    q.g = expand4to10(p.g);
    q.b = expand4to10(p.b);
    return q;
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Small register FIFO absorbing the read pipeline while the downstream sink stalls.
module stream_skid_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic                       valid_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CntW'(push_i) - CntW'(pop_i);
    if (push_i) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_i) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      assert (!(push_i && !pop_i && count_q == CntW'(Depth)));
      assert (!(pop_i && count_q == '0));
    end
  end

endmodule

// File: rtl/frame_stream_reader.sv
// Streams the frame buffer out as Avalon-ST video packets, one packet per frame, in raster order.
module frame_stream_reader
  import video_pkg::*;
#(
  parameter int unsigned H_PIXELS = H_PIXELS_DEF,
  parameter int unsigned V_LINES  = V_LINES_DEF,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned PIX_W    = 12,
  parameter int unsigned OUT_W    = 30
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              resync,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop,
  output logic              frame_done,
  output logic [15:0]       frame_count
);

  localparam int unsigned ColW  = $clog2(H_PIXELS);
  localparam int unsigned RowW  = $clog2(V_LINES);
  localparam int unsigned FifoW = OUT_W + 2;

  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              issue_q, issue_d;
  logic              inflight_q, inflight_d;
  logic              tag_sop_q, tag_sop_d;
  logic              tag_eop_q, tag_eop_d;
  logic              done_q, done_d;
  logic [15:0]       fcount_q, fcount_d;

  logic [1:0]        fifo_count;
  logic              fifo_valid;
  logic [FifoW-1:0]  fifo_head;
  logic [FifoW-1:0]  push_data;
  logic              pop;
  logic              last_col, last_row;
  logic [2:0]        occ;
  pix444_t           rd_pix;
  pix30_t            wide_pix;

  assign rd_pix    = pix444_t'(rd_data);
  assign wide_pix  = expand_pix(rd_pix);
  assign push_data = {tag_sop_q, tag_eop_q, OUT_W'(wide_pix)};
  assign pop       = fifo_valid & out_ready;
  assign last_col  = (col_q == ColW'(H_PIXELS - 1));
  assign last_row  = (row_q == RowW'(V_LINES - 1));

  // Entries committed after this cycle: queued, returning from RAM, being read, minus the pop.
  assign occ = 3'(fifo_count) + 3'(inflight_q) + 3'(issue_q) - 3'(pop);

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    addr_d     = addr_q;
    issue_d    = (occ < 3'd3);
    inflight_d = issue_q;
    tag_sop_d  = tag_sop_q;
    tag_eop_d  = tag_eop_q;
    done_d     = pop & out_eop;
    fcount_d   = fcount_q + 16'(done_d);
    if (issue_q) begin
      tag_sop_d = (row_q == '0) && (col_q == '0);
      tag_eop_d = last_row && last_col;
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
      addr_d = (last_row && last_col) ? '0 : addr_q + ADDR_W'(1);
    end
    if (resync) begin
      col_d      = '0;
      row_d      = '0;
      addr_d     = '0;
      issue_d    = 1'b0;
      inflight_d = 1'b0;
      tag_sop_d  = 1'b0;
      tag_eop_d  = 1'b0;
      done_d     = 1'b0;
      fcount_d   = fcount_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      issue_q    <= 1'b0;
      inflight_q <= 1'b0;
      tag_sop_q  <= 1'b0;
      tag_eop_q  <= 1'b0;
      done_q     <= 1'b0;
      fcount_q   <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      inflight_q <= inflight_d;
      tag_sop_q  <= tag_sop_d;
      tag_eop_q  <= tag_eop_d;
      done_q     <= done_d;
      fcount_q   <= fcount_d;
    end
  end

  stream_skid_fifo #(
    .Width (FifoW),
    .Depth (3)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .flush_i (resync),
    .push_i  (inflight_q),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign rd_addr     = addr_q;
  assign out_valid   = fifo_valid;
  assign out_sop     = fifo_head[FifoW-1];
  assign out_eop     = fifo_head[FifoW-2];
  assign out_data    = fifo_head[OUT_W-1:0];
  assign frame_done  = done_q;
  assign frame_count = fcount_q;

endmodule

// File: tb/tb_frame_stream_reader.sv
// Bench for frame_stream_reader: latency table, frame streaming with a raster reference model.
module tb_frame_stream_reader;

  localparam int H    = 20;
  localparam int V    = 6;
  localparam int NPIX = H * V;
  localparam logic [29:0] PIX_H_EXP = {10'h044, 10'h110, 10'h000};

  logic        clk;
  logic        reset_n;
  logic        resync;
  logic [16:0] rd_addr;
  logic [11:0] rd_data;
  logic [29:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic        frame_done;
  logic [15:0] frame_count;

  frame_stream_reader #(
    .H_PIXELS (H),
    .V_LINES  (V),
    .ADDR_W   (17),
    .PIX_W    (12),
    .OUT_W    (30)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .resync      (resync),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [11:0] mem [NPIX];

  // Frame buffer with one cycle of read latency.
  always @(posedge clk) begin
    int a;
    a = int'(rd_addr);
    rd_data <= (a < NPIX) ? mem[a] : 12'h000;
  end

  typedef struct {
    logic        rst_n;
    logic        rsy;
    logic        rdy;
    logic [16:0] rd_addr;
    logic        valid;
    logic        sop;
  } vec_t;

  vec_t tbl [7];

  int unsigned vectors;
  int unsigned miscompares;
  int          cyc;
  int          exp_idx;
  int          frames;
  int          beats;
  int          done_seen;
  logic        no_gap;

  function automatic logic [29:0] exp_pix(input int idx);
    int p, r, g, b;
    p = int'(mem[idx]);
    r = (p / 256) % 16;
    g = (p / 16) % 16;
    b = p % 16;
    return 30'((r * 68) * 1048576 + (g * 68) * 1024 + b * 68);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One clock: update the reference model from the handshake of the ending cycle, then check.
  task automatic tick();
    logic        rst, rsy, acc, stall, done_exp;
    logic [29:0] hold_data;
    logic        hold_sop, hold_eop;
    rst       = !reset_n;
    rsy       = resync;
    acc       = out_valid && out_ready;
    stall     = out_valid && !out_ready;
    done_exp  = 1'b0;
    hold_data = out_data;
    hold_sop  = out_sop;
    hold_eop  = out_eop;
    if (rst) begin
      exp_idx = 0;
      frames  = 0;
    end else if (rsy) begin
      exp_idx = 0;
    end else if (acc) begin
      chk("beat_data", 64'(out_data), 64'(exp_pix(exp_idx)));
      chk("beat_sop", 64'(out_sop), 64'(exp_idx == 0));
      chk("beat_eop", 64'(out_eop), 64'(exp_idx == NPIX - 1));
      if (exp_idx == H) chk("beat_h_const", 64'(out_data), 64'(PIX_H_EXP));
      beats++;
      if (exp_idx == NPIX - 1) begin
        frames++;
        done_exp = 1'b1;
        exp_idx  = 0;
      end else begin
        exp_idx++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (frame_done === 1'b1) done_seen++;
    chk("frame_done", 64'(frame_done), 64'(done_exp));
    chk("frame_count", 64'(frame_count), 64'(frames[15:0]));
    if (rst || rsy) chk("flush_valid", 64'(out_valid), 64'd0);
    if (!rst && !rsy && stall) begin
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(out_data), 64'(hold_data));
      chk("stall_tags", 64'({out_sop, out_eop}), 64'({hold_sop, hold_eop}));
    end
    if (no_gap) chk("no_gap", 64'(out_valid), 64'd1);
  endtask

  task automatic run_table();
    for (int i = 0; i < 7; i++) begin
      reset_n   = tbl[i].rst_n;
      resync    = tbl[i].rsy;
      out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_rd_addr", i), 64'(rd_addr), 64'(tbl[i].rd_addr));
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].valid));
      chk($sformatf("tbl%0d_sop", i), 64'(out_sop), 64'(tbl[i].sop));
      chk($sformatf("tbl%0d_eop", i), 64'(out_eop), 64'd0);
      if (!tbl[i].valid) chk($sformatf("tbl%0d_data", i), 64'(out_data), 64'd0);
    end
  endtask

  task automatic run_frames(input int target, input int budget, input bit rnd);
    int n;
    n = 0;
    while (frames < target && n < budget) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    chk("frames_reached", 64'(frames >= target), 64'd1);
  endtask

  initial begin
    int b0;
    int n;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    exp_idx     = 0;
    frames      = 0;
    beats       = 0;
    done_seen   = 0;
    no_gap      = 1'b0;
    for (int i = 0; i < NPIX; i++) mem[i] = 12'($urandom);
    mem[0] = 12'h000;
    mem[H] = 12'h140;

    // Reset rows hold reset_n low with resync high; then the post-release latency profile.
    tbl[0] = '{1'b0, 1'b1, 1'b1, 17'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 17'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 17'd0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 17'd1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 17'd2, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 17'd3, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 17'd4, 1'b1, 1'b0};

    reset_n   = 1'b0;
    resync    = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // Latency after reset, then three frames with ready held high and no bubbles.
    run_table();
    no_gap    = 1'b1;
    done_seen = 0;
    run_frames(3, 3 * NPIX + 50, 1'b0);
    no_gap = 1'b0;
    chk("three_frames_done", 64'(done_seen), 64'd3);
    chk("three_frames_count", 64'(frame_count), 64'd3);

    // Stall right after the first beat: reads stop with three pixels outstanding.
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    b0 = beats;
    n  = 0;
    while (beats == b0 && n < 20) begin
      tick();
      n++;
    end
    chk("first_beat_seen", 64'(beats - b0), 64'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_rd_addr", 64'(rd_addr), 64'd4);
    end

    // Random backpressure for two frames; model checks order, tags and stability.
    run_frames(2, 2 * NPIX * 8, 1'b1);

    // Resync mid-frame: stream restarts at pixel 0, frame_count is kept.
    n = 0;
    out_ready = 1'b1;
    while (exp_idx != 50 && n < 4 * NPIX) begin
      tick();
      n++;
    end
    chk("reached_pix50", 64'(exp_idx), 64'd50);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    chk("resync_count_kept", 64'(frame_count), 64'd2);
    run_frames(5, 3 * NPIX * 8, 1'b1);
    out_ready = 1'b1;
    chk("fcnt_pre_reset", 64'(frame_count), 64'd5);

    // Reset together with resync clears everything including frame_count.
    run_table();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
